shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/mul_pkg.sv | 10 +
 rtl/RippleCarryAdder.sv | 31 +++
 rtl/shift_add_multiplier.sv | 98 +++++++++
 tb/tb_shift_add_multiplier.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared constants for the shift-and-add multiplier: FSM encodings and default width.
package mul_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/RippleCarryAdder.sv
// Parameterised ripple-carry adder with carry-out and signed-overflow flag.
module RippleCarryAdder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Overflow
);

    logic carry;
    logic carry_prev;

    // Carry walks LSB to MSB; carry_prev keeps the carry into the MSB for overflow.
    always_comb begin
        carry      = Cin;
        carry_prev = Cin;
        S          = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            S[i]       = a[i] ^ b[i] ^ carry;
            carry_prev = carry;
            carry      = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end

    assign Cout     = carry;
    assign Overflow = carry ^ carry_prev;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one conditional add and right shift per cycle,
// WIDTH cycles per product, done pulses for one cycle when product updates.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               unused_ovf;
    logic [2*WIDTH-1:0] shifted;

    assign addend = acc_q[0] ? mcand_q : '0;

    RippleCarryAdder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a        (acc_q[2*WIDTH-1:WIDTH]),
        .b        (addend),
        .Cin      (1'b0),
        .S        (sum),
        .Cout     (cout),
        .Overflow (unused_ovf)
    );

    // Carry-out becomes the new MSB, so no bit of the partial product is lost.
    assign shifted = {cout, sum, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d = a;
                    acc_d   = {{WIDTH{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = shifted;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    product_d = shifted;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: directed scenarios plus random operands checked against a*b.
module tb_shift_add_multiplier;

    localparam int unsigned WIDTH = 32;
    localparam int          LAT   = 32;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] product;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;

    shift_add_multiplier #(
        .WIDTH(WIDTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        return 64'(x) * 64'(y);
    endfunction

    // Called at a negedge: present operands so the next posedge accepts them.
    task automatic launch(input logic [31:0] ta, input logic [31:0] tb_op);
        start = 1'b1;
        a     = ta;
        b     = tb_op;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Called at the first negedge after the accepting edge.
    task automatic finish_mul(input string tag, input logic [63:0] exp, input logic [63:0] held,
                              input int pulse_at, input bit chain,
                              input logic [31:0] na, input logic [31:0] nb);
        int lat = 0;
        int busy_cycles = 0;
        check_eq({tag, " held"}, product, held);
        while (done !== 1'b1 && lat < LAT + 8) begin
            if (busy === 1'b1) busy_cycles++;
            if (pulse_at != 0 && lat == pulse_at) begin
                start = 1'b1;
                a     = 32'd2;
                b     = 32'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check_eq({tag, " latency"}, 64'(lat), 64'(LAT));
        check_eq({tag, " busy_cycles"}, 64'(busy_cycles), 64'(LAT));
        check_eq({tag, " product"}, product, exp);
        check_eq({tag, " busy_in_done"}, 64'(busy), 64'd0);
        if (chain) begin
            start = 1'b1;
            a     = na;
            b     = nb;
        end
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, " done_pulse"}, 64'(done), 64'd0);
        check_eq({tag, " busy_after"}, 64'(busy), chain ? 64'd1 : 64'd0);
        check_eq({tag, " product_after"}, product, exp);
    endtask

    initial begin
        logic [63:0] last;
        logic [31:0] ra, rb;
        int          dones;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check_eq("reset product", product, 64'd0);
        check_eq("reset busy", 64'(busy), 64'd0);
        check_eq("reset done", 64'(done), 64'd0);

        // First start accepted at the first edge with reset released.
        rst_n = 1'b1;
        launch(32'd3, 32'd5);
        finish_mul("3x5", 64'h000000000000000F, 64'd0, 0, 1'b0, '0, '0);

        launch(32'hFFFFFFFF, 32'hFFFFFFFF);
        finish_mul("max", 64'hFFFFFFFE00000001, 64'hF, 0, 1'b0, '0, '0);

        launch(32'd0, 32'h12345678);
        finish_mul("zero", 64'd0, 64'hFFFFFFFE00000001, 0, 1'b0, '0, '0);

        // start pulse mid-run must be ignored.
        launch(32'd7, 32'd9);
        finish_mul("ignore_start", 64'd63, 64'd0, 10, 1'b0, '0, '0);
        dones = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check_eq("ignore_start extra_done", 64'(dones), 64'd0);

        // Reset mid-run aborts; a start coincident with reset is dropped.
        launch(32'd11, 32'd13);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        a     = 32'd5;
        b     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        check_eq("abort busy", 64'(busy), 64'd0);
        check_eq("abort product", product, 64'd0);
        check_eq("abort done", 64'(done), 64'd0);
        dones = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check_eq("abort no_done", 64'(dones), 64'd0);
        check_eq("abort idle", 64'(busy), 64'd0);
        launch(32'd4, 32'd4);
        finish_mul("after_abort", 64'd16, 64'd0, 0, 1'b0, '0, '0);

        // Back-to-back: start held in DONE launches the next product with no idle cycle.
        launch(32'd3, 32'd5);
        finish_mul("chain1", 64'd15, 64'd16, 0, 1'b1, 32'd6, 32'd7);
        finish_mul("chain2", 64'd42, 64'd15, 0, 1'b0, '0, '0);

        last = 64'd42;
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(3))
                0: begin ra = $urandom_range(255); rb = $urandom_range(255); end
                1: begin ra = $urandom; rb = 32'hFFFFFFFF; end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            repeat ($urandom_range(2)) @(negedge clk);
            launch(ra, rb);
            finish_mul($sformatf("rand%0d", i), ref_mul(ra, rb), last, 0, 1'b0, '0, '0);
            last = ref_mul(ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
